// File: rtl/ysyx_23060025_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI arbiter.
// A grant is held until the owner's read-data or write-response handshake,
// then the arbiter spends one IDLE cycle before the next grant.
// Optional feature macro: ARB_RR_EN selects round-robin between IFU and LSU;
// when undefined, LSU has fixed priority over IFU.
module ysyx_23060025_axi_arbiter #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  // IFU read address / read data
  input  logic [ADDR_LEN-1:0] ifu_addr_r_addr_i,
  input  logic [2:0]          ifu_addr_r_size_i,
  input  logic                ifu_addr_r_valid_i,
  output logic                ifu_addr_r_ready_o,
  output logic [DATA_LEN-1:0] ifu_r_data_o,
  output logic [1:0]          ifu_r_resp_o,
  output logic                ifu_r_valid_o,
  input  logic                ifu_r_ready_i,
  // LSU read address / read data
  input  logic [ADDR_LEN-1:0] lsu_addr_r_addr_i,
  input  logic [2:0]          lsu_addr_r_size_i,
  input  logic                lsu_addr_r_valid_i,
  output logic                lsu_addr_r_ready_o,
  output logic [DATA_LEN-1:0] lsu_r_data_o,
  output logic [1:0]          lsu_r_resp_o,
  output logic                lsu_r_valid_o,
  input  logic                lsu_r_ready_i,
  // LSU write address / write data / write response
  input  logic [ADDR_LEN-1:0] lsu_addr_w_addr_i,
  input  logic [2:0]          lsu_addr_w_size_i,
  input  logic                lsu_addr_w_valid_i,
  output logic                lsu_addr_w_ready_o,
  input  logic [DATA_LEN-1:0] lsu_w_data_i,
  input  logic [3:0]          lsu_w_strb_i,
  input  logic                lsu_w_valid_i,
  output logic                lsu_w_ready_o,
  output logic [1:0]          lsu_bkwd_resp_o,
  output logic                lsu_bkwd_valid_o,
  input  logic                lsu_bkwd_ready_i,
  // Slave side
  output logic [ADDR_LEN-1:0] axi_addr_r_addr_o,
  output logic [2:0]          axi_addr_r_size_o,
  output logic                axi_addr_r_valid_o,
  input  logic                axi_addr_r_ready_i,
  input  logic [DATA_LEN-1:0] axi_r_data_i,
  input  logic [1:0]          axi_r_resp_i,
  input  logic                axi_r_valid_i,
  output logic                axi_r_ready_o,
  output logic [ADDR_LEN-1:0] axi_addr_w_addr_o,
  output logic [2:0]          axi_addr_w_size_o,
  output logic                axi_addr_w_valid_o,
  input  logic                axi_addr_w_ready_i,
  output logic [DATA_LEN-1:0] axi_w_data_o,
  output logic [3:0]          axi_w_strb_o,
  output logic                axi_w_valid_o,
  input  logic                axi_w_ready_i,
  input  logic [1:0]          axi_bkwd_resp_i,
  input  logic                axi_bkwd_valid_i,
  output logic                axi_bkwd_ready_o,
  output logic                bus_err_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    GNT_IFU    = 2'b01,
    GNT_LSU_RD = 2'b10,
    GNT_LSU_WR = 2'b11
  } state_t;

  state_t state;
  state_t state_next;
  logic   bus_err;
  logic   lsu_wr_req;
  logic   lsu_req;
  logic   ifu_wins;
  logic   rd_done;
  logic   wr_done;
  logic   err_next;

  // A write needs both address and data valid; reads only the address.
  assign lsu_wr_req = lsu_addr_w_valid_i & lsu_w_valid_i;
  assign lsu_req    = lsu_wr_req | lsu_addr_r_valid_i;

  // Completing handshakes are seen only through the routed ready, so they
  // can only occur while a matching grant is active.
  assign rd_done  = axi_r_valid_i & axi_r_ready_o;
  assign wr_done  = axi_bkwd_valid_i & axi_bkwd_ready_o;
  assign err_next = (rd_done & (axi_r_resp_i != 2'b00)) |
                    (wr_done & (axi_bkwd_resp_i != 2'b00));

`ifdef ARB_RR_EN
  logic last_lsu;  // 1'b1 when the most recent grant went to the LSU

  assign ifu_wins = ifu_addr_r_valid_i & last_lsu;

  // Remember which master received the latest grant for tie breaking.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_lsu <= 1'b0;
    end else if ((state == IDLE) && (state_next != IDLE)) begin
      last_lsu <= (state_next != GNT_IFU);
    end else begin
      last_lsu <= last_lsu;
    end
  end
`else
  assign ifu_wins = 1'b0;
`endif

  // State register and registered error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      bus_err <= 1'b0;
    end else begin
      state   <= state_next;
      bus_err <= err_next;
    end
  end

  assign bus_err_o = bus_err;

  // Arbitration and grant release.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ifu_addr_r_valid_i & (ifu_wins | ~lsu_req)) begin
          state_next = GNT_IFU;
        end else if (lsu_wr_req) begin
          state_next = GNT_LSU_WR;
        end else if (lsu_addr_r_valid_i) begin
          state_next = GNT_LSU_RD;
        end else begin
          state_next = IDLE;
        end
      end
      GNT_IFU, GNT_LSU_RD: begin
        if (rd_done) state_next = IDLE;
        else         state_next = state;
      end
      GNT_LSU_WR: begin
        if (wr_done) state_next = IDLE;
        else         state_next = state;
      end
      default: state_next = IDLE;
    endcase
  end

  // Channel routing: only the granted master's channels reach the slave.
  always_comb begin
    ifu_addr_r_ready_o = 1'b0;
    ifu_r_data_o       = '0;
    ifu_r_resp_o       = 2'b00;
    ifu_r_valid_o      = 1'b0;
    lsu_addr_r_ready_o = 1'b0;
    lsu_r_data_o       = '0;
    lsu_r_resp_o       = 2'b00;
    lsu_r_valid_o      = 1'b0;
    lsu_addr_w_ready_o = 1'b0;
    lsu_w_ready_o      = 1'b0;
    lsu_bkwd_resp_o    = 2'b00;
    lsu_bkwd_valid_o   = 1'b0;
    axi_addr_r_addr_o  = '0;
    axi_addr_r_size_o  = 3'b000;
    axi_addr_r_valid_o = 1'b0;
    axi_r_ready_o      = 1'b0;
    axi_addr_w_addr_o  = '0;
    axi_addr_w_size_o  = 3'b000;
    axi_addr_w_valid_o = 1'b0;
    axi_w_data_o       = '0;
    axi_w_strb_o       = 4'b0000;
    axi_w_valid_o      = 1'b0;
    axi_bkwd_ready_o   = 1'b0;
    case (state)
      GNT_IFU: begin
        axi_addr_r_addr_o  = ifu_addr_r_addr_i;
        axi_addr_r_size_o  = ifu_addr_r_size_i;
        axi_addr_r_valid_o = ifu_addr_r_valid_i;
        ifu_addr_r_ready_o = axi_addr_r_ready_i;
        ifu_r_data_o       = axi_r_data_i;
        ifu_r_resp_o       = axi_r_resp_i;
        ifu_r_valid_o      = axi_r_valid_i;
        axi_r_ready_o      = ifu_r_ready_i;
      end
      GNT_LSU_RD: begin
        axi_addr_r_addr_o  = lsu_addr_r_addr_i;
        axi_addr_r_size_o  = lsu_addr_r_size_i;
        axi_addr_r_valid_o = lsu_addr_r_valid_i;
        lsu_addr_r_ready_o = axi_addr_r_ready_i;
        lsu_r_data_o       = axi_r_data_i;
        lsu_r_resp_o       = axi_r_resp_i;
        lsu_r_valid_o      = axi_r_valid_i;
        axi_r_ready_o      = lsu_r_ready_i;
      end
      GNT_LSU_WR: begin
        axi_addr_w_addr_o  = lsu_addr_w_addr_i;
        axi_addr_w_size_o  = lsu_addr_w_size_i;
        axi_addr_w_valid_o = lsu_addr_w_valid_i;
        lsu_addr_w_ready_o = axi_addr_w_ready_i;
        axi_w_data_o       = lsu_w_data_i;
        axi_w_strb_o       = lsu_w_strb_i;
        axi_w_valid_o      = lsu_w_valid_i;
        lsu_w_ready_o      = axi_w_ready_i;
        lsu_bkwd_resp_o    = axi_bkwd_resp_i;
        lsu_bkwd_valid_o   = axi_bkwd_valid_i;
        axi_bkwd_ready_o   = lsu_bkwd_ready_i;
      end
      default: begin
        axi_r_ready_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
// Self-checking bench for the AXI arbiter: directed test-plan scenarios plus
// randomized request mixes, judged by a transaction-level arbitration model.
module tb_ysyx_23060025_axi_arbiter;

  typedef enum int {O_NONE, O_IFU, O_LSU_RD, O_LSU_WR} owner_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ifu_addr_r_addr_i;
  logic [2:0]  ifu_addr_r_size_i;
  logic        ifu_addr_r_valid_i;
  logic        ifu_addr_r_ready_o;
  logic [31:0] ifu_r_data_o;
  logic [1:0]  ifu_r_resp_o;
  logic        ifu_r_valid_o;
  logic        ifu_r_ready_i;
  logic [31:0] lsu_addr_r_addr_i;
  logic [2:0]  lsu_addr_r_size_i;
  logic        lsu_addr_r_valid_i;
  logic        lsu_addr_r_ready_o;
  logic [31:0] lsu_r_data_o;
  logic [1:0]  lsu_r_resp_o;
  logic        lsu_r_valid_o;
  logic        lsu_r_ready_i;
  logic [31:0] lsu_addr_w_addr_i;
  logic [2:0]  lsu_addr_w_size_i;
  logic        lsu_addr_w_valid_i;
  logic        lsu_addr_w_ready_o;
  logic [31:0] lsu_w_data_i;
  logic [3:0]  lsu_w_strb_i;
  logic        lsu_w_valid_i;
  logic        lsu_w_ready_o;
  logic [1:0]  lsu_bkwd_resp_o;
  logic        lsu_bkwd_valid_o;
  logic        lsu_bkwd_ready_i;
  logic [31:0] axi_addr_r_addr_o;
  logic [2:0]  axi_addr_r_size_o;
  logic        axi_addr_r_valid_o;
  logic        axi_addr_r_ready_i;
  logic [31:0] axi_r_data_i;
  logic [1:0]  axi_r_resp_i;
  logic        axi_r_valid_i;
  logic        axi_r_ready_o;
  logic [31:0] axi_addr_w_addr_o;
  logic [2:0]  axi_addr_w_size_o;
  logic        axi_addr_w_valid_o;
  logic        axi_addr_w_ready_i;
  logic [31:0] axi_w_data_o;
  logic [3:0]  axi_w_strb_o;
  logic        axi_w_valid_o;
  logic        axi_w_ready_i;
  logic [1:0]  axi_bkwd_resp_i;
  logic        axi_bkwd_valid_i;
  logic        axi_bkwd_ready_o;
  logic        bus_err_o;

  int total = 0;
  int bad   = 0;

  // Transaction payloads for the next serve() call.
  logic [31:0] ifu_addr_v, lr_addr_v, lw_addr_v, lw_data_v, ifu_rdata_v, lr_rdata_v;
  logic [2:0]  ifu_size_v, lr_size_v, lw_size_v;
  logic [3:0]  lw_strb_v;
  logic [1:0]  ifu_resp_v, lr_resp_v, lw_resp_v;
  int          delay_v;
`ifdef ARB_RR_EN
  bit          model_last_lsu;
`endif

  ysyx_23060025_axi_arbiter #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clock(clock), .reset(reset),
    .ifu_addr_r_addr_i(ifu_addr_r_addr_i), .ifu_addr_r_size_i(ifu_addr_r_size_i),
    .ifu_addr_r_valid_i(ifu_addr_r_valid_i), .ifu_addr_r_ready_o(ifu_addr_r_ready_o),
    .ifu_r_data_o(ifu_r_data_o), .ifu_r_resp_o(ifu_r_resp_o),
    .ifu_r_valid_o(ifu_r_valid_o), .ifu_r_ready_i(ifu_r_ready_i),
    .lsu_addr_r_addr_i(lsu_addr_r_addr_i), .lsu_addr_r_size_i(lsu_addr_r_size_i),
    .lsu_addr_r_valid_i(lsu_addr_r_valid_i), .lsu_addr_r_ready_o(lsu_addr_r_ready_o),
    .lsu_r_data_o(lsu_r_data_o), .lsu_r_resp_o(lsu_r_resp_o),
    .lsu_r_valid_o(lsu_r_valid_o), .lsu_r_ready_i(lsu_r_ready_i),
    .lsu_addr_w_addr_i(lsu_addr_w_addr_i), .lsu_addr_w_size_i(lsu_addr_w_size_i),
    .lsu_addr_w_valid_i(lsu_addr_w_valid_i), .lsu_addr_w_ready_o(lsu_addr_w_ready_o),
    .lsu_w_data_i(lsu_w_data_i), .lsu_w_strb_i(lsu_w_strb_i),
    .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_ready_o(lsu_w_ready_o),
    .lsu_bkwd_resp_o(lsu_bkwd_resp_o), .lsu_bkwd_valid_o(lsu_bkwd_valid_o),
    .lsu_bkwd_ready_i(lsu_bkwd_ready_i),
    .axi_addr_r_addr_o(axi_addr_r_addr_o), .axi_addr_r_size_o(axi_addr_r_size_o),
    .axi_addr_r_valid_o(axi_addr_r_valid_o), .axi_addr_r_ready_i(axi_addr_r_ready_i),
    .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i),
    .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o),
    .axi_addr_w_addr_o(axi_addr_w_addr_o), .axi_addr_w_size_o(axi_addr_w_size_o),
    .axi_addr_w_valid_o(axi_addr_w_valid_o), .axi_addr_w_ready_i(axi_addr_w_ready_i),
    .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o),
    .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
    .axi_bkwd_resp_i(axi_bkwd_resp_i), .axi_bkwd_valid_i(axi_bkwd_valid_i),
    .axi_bkwd_ready_o(axi_bkwd_ready_o), .bus_err_o(bus_err_o)
  );

  always #5 clock = ~clock;

  // Every handshake output and every payload output, for all-zero checks.
  wire [11:0] ctl_vec = {axi_addr_r_valid_o, axi_addr_w_valid_o, axi_w_valid_o,
                         axi_r_ready_o, axi_bkwd_ready_o, ifu_addr_r_ready_o,
                         lsu_addr_r_ready_o, lsu_addr_w_ready_o, lsu_w_ready_o,
                         ifu_r_valid_o, lsu_r_valid_o, lsu_bkwd_valid_o};
  wire payload_any = |{axi_addr_r_addr_o, axi_addr_r_size_o, axi_addr_w_addr_o,
                       axi_addr_w_size_o, axi_w_data_o, axi_w_strb_o,
                       ifu_r_data_o, ifu_r_resp_o, lsu_r_data_o, lsu_r_resp_o,
                       lsu_bkwd_resp_o};

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_err);
    chk32({tag, "_ctl"}, 32'(ctl_vec), 32'd0);
    chk1({tag, "_payload"}, payload_any, 1'b0);
    chk1({tag, "_bus_err"}, bus_err_o, exp_err);
  endtask

  // Arbitration rule: a complete LSU write beats an LSU read; LSU beats IFU
  // unless round-robin says the IFU is owed the tie.
  function automatic owner_t pick(input bit i, input bit r, input bit w);
    bit ifu_first;
`ifdef ARB_RR_EN
    ifu_first = i & (!(r | w) | model_last_lsu);
`else
    ifu_first = i & !(r | w);
`endif
    if (ifu_first) return O_IFU;
    if (w)         return O_LSU_WR;
    if (r)         return O_LSU_RD;
    return O_NONE;
  endfunction

  task automatic slave_noise();
    axi_r_valid_i = 1'b1; axi_r_data_i = $urandom; axi_r_resp_i = 2'($urandom);
    axi_bkwd_valid_i = 1'b1; axi_bkwd_resp_i = 2'($urandom);
    axi_addr_r_ready_i = 1'b1; axi_addr_w_ready_i = 1'b1; axi_w_ready_i = 1'b1;
    ifu_r_ready_i = 1'b1; lsu_r_ready_i = 1'b1; lsu_bkwd_ready_i = 1'b1;
  endtask

  task automatic slave_quiet();
    axi_r_valid_i = 1'b0; axi_r_data_i = 32'd0; axi_r_resp_i = 2'b00;
    axi_bkwd_valid_i = 1'b0; axi_bkwd_resp_i = 2'b00;
    axi_addr_r_ready_i = 1'b0; axi_addr_w_ready_i = 1'b0; axi_w_ready_i = 1'b0;
    ifu_r_ready_i = 1'b0; lsu_r_ready_i = 1'b0; lsu_bkwd_ready_i = 1'b0;
  endtask

  task automatic drive_masters(input bit i, input bit r, input bit w);
    ifu_addr_r_valid_i = i; ifu_addr_r_addr_i = ifu_addr_v; ifu_addr_r_size_i = ifu_size_v;
    lsu_addr_r_valid_i = r; lsu_addr_r_addr_i = lr_addr_v;  lsu_addr_r_size_i = lr_size_v;
    lsu_addr_w_valid_i = w; lsu_addr_w_addr_i = lw_addr_v;  lsu_addr_w_size_i = lw_size_v;
    lsu_w_valid_i = w; lsu_w_data_i = lw_data_v; lsu_w_strb_i = lw_strb_v;
  endtask

  task automatic randomize_payload();
    ifu_addr_v = $urandom; lr_addr_v = $urandom; lw_addr_v = $urandom;
    lw_data_v = $urandom; ifu_rdata_v = $urandom; lr_rdata_v = $urandom;
    ifu_size_v = 3'($urandom); lr_size_v = 3'($urandom); lw_size_v = 3'($urandom);
    lw_strb_v = 4'($urandom);
    ifu_resp_v = ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b00;
    lr_resp_v  = ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b00;
    lw_resp_v  = ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b00;
    delay_v = $urandom_range(2, 0);
  endtask

  // Issue the given requests from an IDLE cycle and serve every one of them
  // in arbitration order, checking routing, masking and the error pulse.
  task automatic serve(input bit q_ifu, input bit q_lr, input bit q_lw);
    bit p_ifu, p_lr, p_lw;
    owner_t w;
    logic exp_err;
    logic [1:0] rsp;
    p_ifu = q_ifu; p_lr = q_lr; p_lw = q_lw; exp_err = 1'b0;
    while (p_ifu | p_lr | p_lw) begin
      drive_masters(p_ifu, p_lr, p_lw);
      slave_noise();
      #1;
      chk_idle("idle", exp_err);
      w = pick(p_ifu, p_lr, p_lw);
`ifdef ARB_RR_EN
      model_last_lsu = (w != O_IFU);
`endif
      // Grant cycle: request must be on the slave side one cycle later.
      @(posedge clock); #1;
      slave_quiet();
      #1;
      chk1("err_low", bus_err_o, 1'b0);
      chk1("ar_valid", axi_addr_r_valid_o, w != O_LSU_WR);
      chk1("aw_valid", axi_addr_w_valid_o, w == O_LSU_WR);
      chk1("w_valid",  axi_w_valid_o,      w == O_LSU_WR);
      if (w == O_IFU) begin
        chk32("ar_addr_ifu", axi_addr_r_addr_o, ifu_addr_v);
        chk32("ar_size_ifu", 32'(axi_addr_r_size_o), 32'(ifu_size_v));
      end else if (w == O_LSU_RD) begin
        chk32("ar_addr_lsu", axi_addr_r_addr_o, lr_addr_v);
        chk32("ar_size_lsu", 32'(axi_addr_r_size_o), 32'(lr_size_v));
      end else begin
        chk32("aw_addr", axi_addr_w_addr_o, lw_addr_v);
        chk32("aw_size", 32'(axi_addr_w_size_o), 32'(lw_size_v));
        chk32("w_data", axi_w_data_o, lw_data_v);
        chk32("w_strb", 32'(axi_w_strb_o), 32'(lw_strb_v));
      end
      axi_addr_r_ready_i = 1'b1; axi_addr_w_ready_i = 1'b1; axi_w_ready_i = 1'b1;
      #1;
      chk1("ifu_ar_ready", ifu_addr_r_ready_o, w == O_IFU);
      chk1("lsu_ar_ready", lsu_addr_r_ready_o, w == O_LSU_RD);
      chk1("lsu_aw_ready", lsu_addr_w_ready_o, w == O_LSU_WR);
      chk1("lsu_w_ready",  lsu_w_ready_o,      w == O_LSU_WR);
      @(posedge clock); #1;
      if (w == O_IFU)         p_ifu = 1'b0;
      else if (w == O_LSU_RD) p_lr = 1'b0;
      else                    p_lw = 1'b0;
      drive_masters(p_ifu, p_lr, p_lw);
      for (int k = 0; k < delay_v; k++) begin
        #1;
        chk1("hold_ifu_ready", ifu_addr_r_ready_o, w == O_IFU);
        chk1("hold_lsu_aw_ready", lsu_addr_w_ready_o, w == O_LSU_WR);
        @(posedge clock); #1;
      end
      // Response cycle: slave presents both response channels; only the
      // owner's one may pass.
      slave_noise();
      axi_addr_r_ready_i = 1'b0; axi_addr_w_ready_i = 1'b0; axi_w_ready_i = 1'b0;
      if (w == O_IFU) begin
        axi_r_data_i = ifu_rdata_v; axi_r_resp_i = ifu_resp_v; rsp = ifu_resp_v;
      end else if (w == O_LSU_RD) begin
        axi_r_data_i = lr_rdata_v; axi_r_resp_i = lr_resp_v; rsp = lr_resp_v;
      end else begin
        axi_bkwd_resp_i = lw_resp_v; rsp = lw_resp_v;
      end
      #1;
      chk1("ifu_r_valid", ifu_r_valid_o, w == O_IFU);
      chk1("lsu_r_valid", lsu_r_valid_o, w == O_LSU_RD);
      chk1("lsu_b_valid", lsu_bkwd_valid_o, w == O_LSU_WR);
      chk1("axi_r_ready", axi_r_ready_o, w != O_LSU_WR);
      chk1("axi_b_ready", axi_bkwd_ready_o, w == O_LSU_WR);
      if (w == O_IFU) begin
        chk32("ifu_r_data", ifu_r_data_o, ifu_rdata_v);
        chk32("ifu_r_resp", 32'(ifu_r_resp_o), 32'(rsp));
      end else if (w == O_LSU_RD) begin
        chk32("lsu_r_data", lsu_r_data_o, lr_rdata_v);
        chk32("lsu_r_resp", 32'(lsu_r_resp_o), 32'(rsp));
      end else begin
        chk32("lsu_b_resp", 32'(lsu_bkwd_resp_o), 32'(rsp));
      end
      @(posedge clock); #1;
      slave_quiet();
      exp_err = (rsp != 2'b00);
    end
    drive_masters(1'b0, 1'b0, 1'b0);
    #1;
    chk_idle("tail", exp_err);
    @(posedge clock); #1;
    chk1("tail_err_clear", bus_err_o, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    randomize_payload();
    drive_masters(1'b0, 1'b0, 1'b0);
    slave_quiet();
`ifdef ARB_RR_EN
    model_last_lsu = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk_idle("reset", 1'b0);

    // IFU read alone.
    randomize_payload();
    ifu_addr_v = 32'h8000_0000; ifu_rdata_v = 32'h1234_5678; ifu_resp_v = 2'b00; delay_v = 1;
    serve(1'b1, 1'b0, 1'b0);

    // LSU store while IFU also waits.
    randomize_payload();
    lw_addr_v = 32'h0F00_0002; lw_size_v = 3'd1; lw_data_v = 32'h0000_00AB;
    lw_strb_v = 4'b0100; lw_resp_v = 2'b00; delay_v = 2;
    serve(1'b1, 1'b0, 1'b1);

    // Simultaneous reads, twice.
    randomize_payload(); ifu_resp_v = 2'b00; lr_resp_v = 2'b00;
    serve(1'b1, 1'b1, 1'b0);
    randomize_payload(); ifu_resp_v = 2'b00; lr_resp_v = 2'b00;
    serve(1'b1, 1'b1, 1'b0);

    // Error response on an LSU read, then a clean IFU read.
    randomize_payload(); lr_resp_v = 2'b10;
    serve(1'b0, 1'b1, 1'b0);
    randomize_payload(); ifu_resp_v = 2'b00;
    serve(1'b1, 1'b0, 1'b0);

    // Reset while a write is granted and no response has arrived.
    randomize_payload();
    drive_masters(1'b0, 1'b0, 1'b1);
    #1;
    @(posedge clock); #1;
    #1;
    chk1("wr_granted", axi_addr_w_valid_o, 1'b1);
    reset = 1'b1;
    drive_masters(1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
`ifdef ARB_RR_EN
    model_last_lsu = 1'b0;
`endif
    #1;
    chk_idle("after_reset", 1'b0);
    randomize_payload();
    serve(1'b1, 1'b0, 1'b0);

    // Random request mixes.
    for (int n = 0; n < 40; n++) begin
      bit ri, rr, rw;
      randomize_payload();
      ri = 1'($urandom); rr = 1'($urandom); rw = 1'($urandom);
      if (!(ri | rr | rw)) ri = 1'b1;
      serve(ri, rr, rw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_axi_arbiter.md
# ysyx_23060025_axi_arbiter

- Two-master, one-slave arbiter between the core's fetch and memory stages and the single system AXI port.
- Masters: IFU, read-only; LSU, read and write.
- Grants one master at a time and holds the grant until that master's transaction completes: read data handshake, or write-response handshake.
- Routes only the granted master's channels to the slave.

## Interface
Parameters:
- DATA_LEN, 32, data width.
- ADDR_LEN, 32, address width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ifu_addr_r_{addr,size,valid}_i / ifu_addr_r_ready_o  in/out  ADDR_LEN,3,1 / 1  IFU read-address channel.
- ifu_r_{data,resp,valid}_o / ifu_r_ready_i  out/in  DATA_LEN,2,1 / 1  IFU read-data channel.
- lsu_addr_r_{addr,size,valid}_i / lsu_addr_r_ready_o  in/out  ADDR_LEN,3,1 / 1  LSU read-address channel.
- lsu_r_{data,resp,valid}_o / lsu_r_ready_i  out/in  DATA_LEN,2,1 / 1  LSU read-data channel.
- lsu_addr_w_{addr,size,valid}_i / lsu_addr_w_ready_o  in/out  ADDR_LEN,3,1 / 1  LSU write-address channel.
- lsu_w_{data,strb,valid}_i / lsu_w_ready_o  in/out  DATA_LEN,4,1 / 1  LSU write-data channel.
- lsu_bkwd_{resp,valid}_o / lsu_bkwd_ready_i  out/in  2,1 / 1  LSU write-response channel.
- Slave side, mirror of the above with prefix `axi_`:
  - axi_addr_r_*, axi_r_*, axi_addr_w_*, axi_w_*, axi_bkwd_*.
  - Directions inverted relative to the master side.
- bus_err_o  out  1  one-cycle pulse after any completed transaction whose resp is nonzero.

## Operation
State register values:
- IDLE = 2'b00, GNT_IFU = 2'b01, GNT_LSU_RD = 2'b10, GNT_LSU_WR = 2'b11.

IDLE:
- Every slave-side valid/ready is 0.
- Every master-side ready/valid is 0.
- Payload outputs are 0.
- Next-state selection, in priority order (fixed priority, macro absent):
  - lsu_addr_w_valid_i & lsu_w_valid_i → GNT_LSU_WR.
  - else lsu_addr_r_valid_i → GNT_LSU_RD.
  - else ifu_addr_r_valid_i → GNT_IFU.
  - else stay in IDLE.

GNT_IFU / GNT_LSU_RD:
- The granted master's read-address and read-data channels are wired combinationally to axi_addr_r_* and axi_r_*.
- Slave write channels are driven 0.
- All channels of the other master are masked to 0.
- Exit to IDLE in the cycle after axi_r_valid_i & axi_r_ready_o.

GNT_LSU_WR:
- The LSU write-address, write-data and write-response channels are routed to the slave.
- Slave read channels are driven 0.
- IFU ready/valid outputs are held at 0.
- Exit to IDLE in the cycle after axi_bkwd_valid_i & axi_bkwd_ready_o.

Response handling:
- resp passes through unmodified.
- Grant is released on the handshake regardless of resp value.
- bus_err_o is registered: it goes high the cycle after a completing handshake with resp != 2'b00, for exactly one cycle.

Masking and payload rules:
- A master whose valid drops while ungranted is simply not selected. No state is kept for it.
- Address, size, data and strobe are passed bit-exact with no width conversion.
- Upper bits are never altered.

## Timing
Reset:
- reset high at an edge forces state to IDLE, the last-grant register to IFU, and bus_err_o to 0.
- Every output is therefore 0 in the following cycle.
- An in-flight slave transaction is abandoned and not replayed.

Latency:
- Arbitration costs 1 cycle: a request first seen in IDLE reaches the slave side in the next cycle. Masters hold valid per AXI, so no payload is lost.
- Minimum spacing between transactions is 1 IDLE cycle. A completing handshake and a new request in the same cycle go to IDLE first; the grant follows one cycle later.

Handshake rules:
- Write address and write data are routed together. Each slave ready is forwarded independently.
- The arbiter never drives a master valid or slave valid unless that master is granted.

Simultaneous requests in IDLE:
- Resolved by the priority rule.
- A lower-priority master waits with valid high indefinitely until granted (no timeout).

## Configuration
ARB_RR_EN:
- Defined: round-robin arbitration between IFU and LSU.
  - A last-grant register is updated on each grant.
  - When both masters request in IDLE, the master not granted last wins.
  - After reset the LSU wins the first tie (last-grant resets to IFU).
  - Write-before-read ordering within the LSU is unchanged.
- Undefined: fixed priority, LSU above IFU.
  - The last-grant register is absent or unused.

## Test plan
- IFU read alone:
  - Stimulus: ifu valid with addr 0x8000_0000 at cycle 0; slave ready at cycle 1; r_data 0x1234_5678, resp 0 at cycle 3.
  - Response: axi_addr_r_valid_o high at cycle 1; ifu_r_data_o 0x1234_5678 at cycle 3; state IDLE at cycle 4.
- LSU store:
  - Stimulus: addr 0x0F00_0002, size 1, data 0x0000_00AB, strb 4'b0100.
  - Response: identical values on axi_addr_w/axi_w; grant held until the bkwd handshake; IFU ready stays 0 throughout.
- Simultaneous IFU and LSU read in IDLE:
  - Without ARB_RR_EN: LSU granted first, IFU second.
  - With ARB_RR_EN: second tie after an LSU grant goes to IFU.
- Error response:
  - Stimulus: LSU read completes with r_resp 2'b10.
  - Response: resp forwarded; bus_err_o high exactly one cycle; next grant proceeds normally.
- Reset during GNT_LSU_WR, before bkwd_valid:
  - Response: all outputs 0 next cycle; a subsequent IFU request is granted with normal 1-cycle latency.
